// File: rtl/gpu_primitive_receiver_pkg.sv
// Shared widths, primitive entry layout and output-stage state encoding for the
// writeback->GPU primitive receiver.
package gpu_primitive_receiver_pkg;

  localparam int GSR_WIDTH        = 32;
  localparam int VERTEX_REG_WIDTH = 32;
  localparam int PRIM_WIDTH       = GSR_WIDTH + 3 * VERTEX_REG_WIDTH;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_e;

  // True when any two vertices are identical, i.e. the triangle has zero area.
  function automatic logic is_degenerate(
    input logic [VERTEX_REG_WIDTH-1:0] v1,
    input logic [VERTEX_REG_WIDTH-1:0] v2,
    input logic [VERTEX_REG_WIDTH-1:0] v3
  );
    return (v1 == v2) || (v2 == v3) || (v1 == v3);
  endfunction

endpackage

// File: rtl/gpu_prim_fifo.sv
// Primitive entry FIFO: power-of-2 depth, occupancy count, negedge-clocked,
// async active-low clear. Concurrent push+pop is allowed when full.
module gpu_prim_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gpu_primitive_receiver.sv
// GPU-side receiver for writeback primitives: FIFO buffering, stall, ordered output stage.
// Optional degenerate-triangle culling when GPU_DEGEN_CULL_EN is defined.
module gpu_primitive_receiver
  import gpu_primitive_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STALL_SKID = 1
) (
  input  logic                        I_CLOCK,
  input  logic                        I_LOCK,
  input  logic [GSR_WIDTH-1:0]        I_GSRValue,
  input  logic [VERTEX_REG_WIDTH-1:0] I_VertexV1,
  input  logic [VERTEX_REG_WIDTH-1:0] I_VertexV2,
  input  logic [VERTEX_REG_WIDTH-1:0] I_VertexV3,
  input  logic                        I_GSRValue_Valid,
  output logic                        O_GPUStallSignal,
  output logic                        O_PrimValid,
  input  logic                        I_PrimReady,
  output logic [GSR_WIDTH-1:0]        O_PrimGSR,
  output logic [VERTEX_REG_WIDTH-1:0] O_PrimV1,
  output logic [VERTEX_REG_WIDTH-1:0] O_PrimV2,
  output logic [VERTEX_REG_WIDTH-1:0] O_PrimV3,
`ifdef GPU_DEGEN_CULL_EN
  output logic [7:0]                  O_CullCount,
`endif
  output logic                        O_Overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PRIM_WIDTH-1:0] in_word;
  logic [PRIM_WIDTH-1:0] out_word;
  logic [PRIM_WIDTH-1:0] fifo_rd;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  cull;
  logic                  push_req;
  logic                  out_free;
  logic                  bypass;
  logic                  drop;
  out_state_e            state;

  assign in_word = {I_GSRValue, I_VertexV1, I_VertexV2, I_VertexV3};
  assign {O_PrimGSR, O_PrimV1, O_PrimV2, O_PrimV3} = out_word;

`ifdef GPU_DEGEN_CULL_EN
  assign cull = I_GSRValue_Valid && is_degenerate(I_VertexV1, I_VertexV2, I_VertexV3);
`else
  assign cull = 1'b0;
`endif

  assign push_req  = I_GSRValue_Valid && !cull;
  assign out_free  = (state == S_EMPTY) || I_PrimReady;
  assign fifo_pop  = out_free && !fifo_empty;
  // Bypass only when nothing older is queued, so arrival order is preserved.
  assign bypass    = push_req && fifo_empty && out_free;
  assign fifo_push = push_req && !bypass && (!fifo_full || fifo_pop);
  assign drop      = push_req && !bypass && fifo_full && !fifo_pop;

  assign O_GPUStallSignal = (fifo_count >= CNT_W'(FIFO_DEPTH - STALL_SKID));

  gpu_prim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PRIM_WIDTH)
  ) u_fifo (
    .clk     (I_CLOCK),
    .rst_n   (I_LOCK),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in_word),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state       <= S_EMPTY;
      O_PrimValid <= 1'b0;
      out_word    <= '0;
      O_Overflow  <= 1'b0;
    end else begin
      if (drop) O_Overflow <= 1'b1;
      if (out_free) begin
        if (fifo_pop) begin
          state       <= S_FULL;
          O_PrimValid <= 1'b1;
          out_word    <= fifo_rd;
        end else if (bypass) begin
          state       <= S_FULL;
          O_PrimValid <= 1'b1;
          out_word    <= in_word;
        end else begin
          state       <= S_EMPTY;
          O_PrimValid <= 1'b0;
        end
      end
    end
  end

`ifdef GPU_DEGEN_CULL_EN
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      O_CullCount <= '0;
    end else if (cull && (O_CullCount != 8'hFF)) begin
      O_CullCount <= O_CullCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_primitive_receiver.sv
// Directed bench for gpu_primitive_receiver: reset, fill/overflow, drain order,
// full push+pop, async reset mid-burst, and degenerate culling under GPU_DEGEN_CULL_EN.
module tb_gpu_primitive_receiver;

  logic        I_CLOCK;
  logic        I_LOCK;
  logic [31:0] I_GSRValue;
  logic [31:0] I_VertexV1;
  logic [31:0] I_VertexV2;
  logic [31:0] I_VertexV3;
  logic        I_GSRValue_Valid;
  logic        O_GPUStallSignal;
  logic        O_PrimValid;
  logic        I_PrimReady;
  logic [31:0] O_PrimGSR;
  logic [31:0] O_PrimV1;
  logic [31:0] O_PrimV2;
  logic [31:0] O_PrimV3;
  logic        O_Overflow;
`ifdef GPU_DEGEN_CULL_EN
  logic [7:0]  O_CullCount;
`endif

  int tests = 0;
  int fails = 0;

  gpu_primitive_receiver #(.FIFO_DEPTH(4), .STALL_SKID(1)) dut (
    .I_CLOCK          (I_CLOCK),
    .I_LOCK           (I_LOCK),
    .I_GSRValue       (I_GSRValue),
    .I_VertexV1       (I_VertexV1),
    .I_VertexV2       (I_VertexV2),
    .I_VertexV3       (I_VertexV3),
    .I_GSRValue_Valid (I_GSRValue_Valid),
    .O_GPUStallSignal (O_GPUStallSignal),
    .O_PrimValid      (O_PrimValid),
    .I_PrimReady      (I_PrimReady),
    .O_PrimGSR        (O_PrimGSR),
    .O_PrimV1         (O_PrimV1),
    .O_PrimV2         (O_PrimV2),
    .O_PrimV3         (O_PrimV3),
`ifdef GPU_DEGEN_CULL_EN
    .O_CullCount      (O_CullCount),
`endif
    .O_Overflow       (O_Overflow)
  );

  initial I_CLOCK = 1'b1;
  always #5 I_CLOCK = ~I_CLOCK;

  function automatic logic [127:0] pk(input int k);
    return {32'h100 + 32'(k), 32'h1000 + 32'(k), 32'h2000 + 32'(k), 32'h3000 + 32'(k)};
  endfunction

  function automatic logic [127:0] out_word();
    return {O_PrimGSR, O_PrimV1, O_PrimV2, O_PrimV3};
  endfunction

  task automatic drive(input logic [127:0] w);
    {I_GSRValue, I_VertexV1, I_VertexV2, I_VertexV3} = w;
    I_GSRValue_Valid = 1'b1;
  endtask

  // Advance past the active (falling) edge and settle before sampling.
  task automatic tick();
    @(negedge I_CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    I_LOCK = 1'b0;
    #2;
    I_LOCK = 1'b1;
  endtask

  initial begin
    I_LOCK = 1'b0;
    I_PrimReady = 1'b0;
    drive(pk(1));

    // 1. Reset held with valid asserted, then a single bypass push
    tick();
    tick();
    check("rst_valid", 128'(O_PrimValid), 128'd0);
    check("rst_stall", 128'(O_GPUStallSignal), 128'd0);
    check("rst_ovf", 128'(O_Overflow), 128'd0);
    check("rst_data", out_word(), 128'd0);
    #2;
    I_LOCK = 1'b1;
    drive({32'd5, 32'd1, 32'd2, 32'd3});
    tick();
    I_GSRValue_Valid = 1'b0;
    check("bypass_valid", 128'(O_PrimValid), 128'd1);
    check("bypass_data", out_word(), {32'd5, 32'd1, 32'd2, 32'd3});

    // 2. Fill with ready low: 1 in output regs, 4 queued, 6th dropped
    reset_pulse();
    I_PrimReady = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(pk(k));
      tick();
      check($sformatf("fill_stall_%0d", k), 128'(O_GPUStallSignal), 128'(k >= 4));
      check($sformatf("fill_ovf_%0d", k), 128'(O_Overflow), 128'd0);
    end
    check("fill_head", out_word(), pk(1));
    drive(pk(6));
    tick();
    I_GSRValue_Valid = 1'b0;
    check("ovf_set", 128'(O_Overflow), 128'd1);
    check("ovf_head", out_word(), pk(1));

    // 3. Drain in order, stall falls once two entries have left
    I_PrimReady = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      check($sformatf("drain_valid_%0d", j), 128'(O_PrimValid), 128'd1);
      check($sformatf("drain_data_%0d", j), out_word(), pk(j));
      check($sformatf("drain_stall_%0d", j), 128'(O_GPUStallSignal), 128'(j <= 2));
      tick();
    end
    check("drain_empty", 128'(O_PrimValid), 128'd0);
    check("ovf_sticky", 128'(O_Overflow), 128'd1);

    // 4. Push and pop on the same edge with the FIFO full
    reset_pulse();
    I_PrimReady = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(pk(k));
      tick();
    end
    I_PrimReady = 1'b1;
    drive(pk(6));
    tick();
    I_GSRValue_Valid = 1'b0;
    check("pp_ovf", 128'(O_Overflow), 128'd0);
    check("pp_stall", 128'(O_GPUStallSignal), 128'd1);
    check("pp_head", out_word(), pk(2));
    for (int j = 3; j <= 6; j++) begin
      tick();
      check($sformatf("pp_order_%0d", j), out_word(), pk(j));
    end
    tick();
    check("pp_empty", 128'(O_PrimValid), 128'd0);

    // 5. Async reset between edges with entries queued
    reset_pulse();
    I_PrimReady = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(pk(k));
      tick();
    end
    I_GSRValue_Valid = 1'b0;
    check("ar_pre_data", out_word(), pk(1));
    #2;
    I_LOCK = 1'b0;
    #1;
    check("ar_valid", 128'(O_PrimValid), 128'd0);
    check("ar_data", out_word(), 128'd0);
    #1;
    I_LOCK = 1'b1;
    drive(pk(9));
    tick();
    I_GSRValue_Valid = 1'b0;
    check("ar_new_data", out_word(), pk(9));
    I_PrimReady = 1'b1;
    tick();
    check("ar_no_stale", 128'(O_PrimValid), 128'd0);

`ifdef GPU_DEGEN_CULL_EN
    // 6. Degenerate primitive is swallowed and counted
    reset_pulse();
    I_PrimReady = 1'b0;
    drive({32'd4, 32'd7, 32'd7, 32'd9});
    tick();
    check("cull_valid", 128'(O_PrimValid), 128'd0);
    check("cull_count", 128'(O_CullCount), 128'd1);
    drive(pk(11));
    tick();
    I_GSRValue_Valid = 1'b0;
    check("cull_next_valid", 128'(O_PrimValid), 128'd1);
    check("cull_next_data", out_word(), pk(11));
    check("cull_count_hold", 128'(O_CullCount), 128'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
